plot_fb_scanout: RTL and testbench

// - Sink for the game's plot interface (x, y, colour, plot strobe). Stores pixels in an

---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_skid.sv | 75 +++++++
 rtl/plot_fb_scanout.sv | 185 ++++++++++++++++++
 tb/tb_plot_fb_scanout.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the plot framebuffer and its raster scanout.
package fb_pkg;

  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int FB_AW = 15;
  localparam int FB_CW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2
  } fb_state_t;

  typedef struct packed {
    logic [7:0]       x;
    logic [6:0]       y;
    logic [FB_CW-1:0] colour;
  } pix_t;

  // Linear address y*w + x built as a constant shift-and-add over the set bits
  // of w, so no multiplier is inferred (w=160 gives (y<<7)+(y<<5)+x).
  function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x,
                                               input logic [6:0] y,
                                               input int         w);
    logic [FB_AW-1:0] acc;
    acc = FB_AW'(x);
    for (int b = 0; b < FB_AW; b++) begin
      if (w[b]) acc = acc + (FB_AW'(y) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_skid.sv
// Two-entry skid buffer for scanout pixels. The head register drives the
// stream directly; the spare entry catches a read that was already in flight
// when the consumer stalled.
//
// Handshake: a beat transfers on a rising edge where out_valid_o && out_ready_i.
// Once out_valid_o is high, out_data_o holds until that transfer happens.
// The producer never pushes into a full buffer (it budgets with count_o).
module fb_skid
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  pix_t       in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output pix_t       out_data_o,
  output logic [1:0] count_o
);

  logic out_valid_q, out_valid_d;
  pix_t out_q, out_d;
  logic spare_valid_q, spare_valid_d;
  pix_t spare_q, spare_d;
  logic pop;
  logic head_free;

  assign pop       = out_valid_q && out_ready_i;
  assign head_free = pop || !out_valid_q;

  // Next-state: refill the head from spare first (oldest), then from input.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_d         = out_q;
    spare_valid_d = spare_valid_q;
    spare_d       = spare_q;
    if (head_free) begin
      if (spare_valid_q) begin
        out_valid_d   = 1'b1;
        out_d         = spare_q;
        spare_valid_d = 1'b0;
        if (in_valid_i) begin
          spare_valid_d = 1'b1;
          spare_d       = in_data_i;
        end
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) out_d = in_data_i;
      end
    end else if (in_valid_i) begin
      spare_valid_d = 1'b1;
      spare_d       = in_data_i;
    end
  end

  // Register both entries; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      spare_valid_q <= 1'b0;
      spare_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
      spare_valid_q <= spare_valid_d;
      spare_q       <= spare_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign count_o     = {1'b0, out_valid_q} + {1'b0, spare_valid_q};

endmodule

// File: rtl/plot_fb_scanout.sv
// Pixel framebuffer: accepts plot writes, clears itself after reset or on
// request, and streams a full frame in raster order on scan_start.
module plot_fb_scanout
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_W,
  parameter int HEIGHT = FB_H,
  parameter int CW     = FB_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    plot_x,
  input  logic [6:0]    plot_y,
  input  logic [CW-1:0] plot_colour,
  input  logic          plot,
  output logic          plot_busy,
  output logic          plot_drop,
  input  logic          clear_req,
  input  logic          scan_start,
  output logic          scan_busy,
  output logic [7:0]    pix_x,
  output logic [6:0]    pix_y,
  output logic [CW-1:0] pix_colour,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          frame_done,
  output fb_state_t     dbg_state
);

  localparam int               NPIX      = WIDTH * HEIGHT;
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(NPIX - 1);
  localparam logic [7:0]       X_LAST    = 8'(WIDTH - 1);
  localparam logic [6:0]       Y_LAST    = 7'(HEIGHT - 1);

  fb_state_t        state_q;
  logic [FB_AW-1:0] clear_addr_q;
  logic [7:0]       rx_q;
  logic [6:0]       ry_q;
  logic             rd_done_q;
  logic             plot_drop_q;

  logic             rd_vld_q;
  logic [7:0]       rd_x_q;
  logic [6:0]       rd_y_q;
  logic [CW-1:0]    rd_colour_q;

  logic [CW-1:0]    mem [NPIX];

  logic             plot_in_range;
  logic             clear_accept;
  logic             scan_accept;
  logic             xfer;
  logic             last_xfer;
  logic             room;
  logic             rd_issue;
  logic [1:0]       occ;
  logic             we;
  logic [FB_AW-1:0] waddr;
  logic [CW-1:0]    wdata;
  logic [FB_AW-1:0] raddr;
  pix_t             rd_pix;
  pix_t             pix_q;

  assign plot_in_range = (plot_x <= X_LAST) && (plot_y <= Y_LAST);
  assign clear_accept  = (state_q == IDLE) && clear_req;
  assign scan_accept   = (state_q == IDLE) && scan_start && !clear_req;
  assign xfer          = pix_valid && pix_ready;
  assign last_xfer     = xfer && (state_q == SCAN) &&
                         (pix_q.x == X_LAST) && (pix_q.y == Y_LAST);

  // A read lands in the skid one cycle later; only issue if it will fit then.
  assign room     = ({1'b0, occ} + {2'b0, rd_vld_q}) < ({2'b0, xfer} + 3'd2);
  assign rd_issue = scan_accept || ((state_q == SCAN) && !rd_done_q && room);
  assign raddr    = fb_addr(rx_q, ry_q, WIDTH);

  // Write-port arbitration: the clear counter owns it in CLEAR, plot otherwise.
  always_comb begin
    we    = 1'b0;
    waddr = fb_addr(plot_x, plot_y, WIDTH);
    wdata = plot_colour;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = clear_addr_q;
      wdata = '0;
    end else if (plot && plot_in_range) begin
      we = 1'b1;
    end
  end

  // Control FSM with clear counter, raster read pointer and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clear_addr_q <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      rd_done_q    <= 1'b0;
      plot_drop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
          end else if (scan_start) begin
            state_q <= SCAN;
          end
        end
        CLEAR: begin
          clear_addr_q <= clear_addr_q + 1'b1;
          if (clear_addr_q == LAST_ADDR) begin
            state_q      <= IDLE;
            clear_addr_q <= '0;
          end
        end
        SCAN: begin
          if (last_xfer) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (rd_issue) begin
        if (rx_q == X_LAST) begin
          rx_q <= '0;
          if (ry_q == Y_LAST) rd_done_q <= 1'b1;
          else                ry_q      <= ry_q + 1'b1;
        end else begin
          rx_q <= rx_q + 1'b1;
        end
      end
      if (last_xfer) begin
        rx_q      <= '0;
        ry_q      <= '0;
        rd_done_q <= 1'b0;
      end

      if (clear_accept) plot_drop_q <= 1'b0;
      if ((state_q != CLEAR) && plot && !plot_in_range) plot_drop_q <= 1'b1;
    end
  end

  // Coordinates travel alongside the one-cycle RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_x_q   <= '0;
      rd_y_q   <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_x_q <= rx_q;
        rd_y_q <= ry_q;
      end
    end
  end

  // Framebuffer RAM: unreset, read-first, one write and one read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (rd_issue) rd_colour_q <= mem[raddr];
  end

  assign rd_pix = {rd_x_q, rd_y_q, rd_colour_q};

  fb_skid u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (rd_vld_q),
    .in_data_i   (rd_pix),
    .out_valid_o (pix_valid),
    .out_ready_i (pix_ready),
    .out_data_o  (pix_q),
    .count_o     (occ)
  );

  assign pix_x      = pix_q.x;
  assign pix_y      = pix_q.y;
  assign pix_colour = pix_q.colour;
  assign frame_done = last_xfer;
  assign plot_busy  = (state_q == CLEAR);
  assign scan_busy  = (state_q == SCAN);
  assign plot_drop  = plot_drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_plot_fb_scanout.sv
// Directed bench for plot_fb_scanout: auto-clear timing, plotting, drop flag,
// raster scanout under steady and random backpressure, clear/scan collision
// and reset during a scan.
module tb_plot_fb_scanout;
  import fb_pkg::*;

  localparam int NPIX = 160 * 120;

  logic       clk;
  logic       rst_n;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot;
  logic       plot_busy;
  logic       plot_drop;
  logic       clear_req;
  logic       scan_start;
  logic       scan_busy;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_valid;
  logic       pix_ready;
  logic       frame_done;
  fb_state_t  dbg_state;

  int n_cmp;
  int n_fail;

  plot_fb_scanout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot        (plot),
    .plot_busy   (plot_busy),
    .plot_drop   (plot_drop),
    .clear_req   (clear_req),
    .scan_start  (scan_start),
    .scan_busy   (scan_busy),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colour  (pix_colour),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_col(input int idx, input bit pat);
    if (pat && idx == 323)   return 3'b100;
    if (pat && idx == 19199) return 3'b010;
    return 3'b000;
  endfunction

  // Called at a negedge: counts cycles with plot_busy high.
  task automatic count_busy(output int n);
    n = 0;
    while (plot_busy && n < 30000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    plot = 1'b1; plot_x = x; plot_y = y; plot_colour = c;
    @(negedge clk);
    plot = 1'b0;
  endtask

  // Starts a scan and checks every transfer against the raster model.
  // stop_at >= 0 returns while pixel stop_at is presented, before it transfers.
  task automatic run_scan(input int stop_at, input int rand_cycles, input bit pat);
    int         idx;
    int         cyc;
    bit         hold;
    bit         stopped;
    logic [18:0] held;
    logic [18:0] exp_pk;
    idx = 0; cyc = 0; hold = 0; stopped = 0; held = '0;
    scan_start = 1'b1;
    pix_ready  = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    #1;
    check("scan_busy_on_accept", scan_busy, 1);
    check("valid_one_cycle_after_accept", pix_valid, 0);
    while (idx < NPIX && cyc < 60000) begin
      @(negedge clk);
      pix_ready = (cyc < rand_cycles) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) check("valid_two_cycles_after_accept", pix_valid, 1);
      if (hold) check("stall_stable", {pix_valid, pix_x, pix_y, pix_colour}, held);
      if (pix_valid && pix_ready) begin
        if (idx == stop_at) begin
          stopped = 1;
          break;
        end
        exp_pk = {8'(idx % 160), 7'(idx / 160), exp_col(idx, pat), (idx == NPIX - 1)};
        check("pixel", {pix_x, pix_y, pix_colour, frame_done}, exp_pk);
        idx++;
      end else begin
        check("frame_done_quiet", frame_done, 0);
      end
      hold = pix_valid && !pix_ready;
      held = {pix_valid, pix_x, pix_y, pix_colour};
      cyc++;
    end
    if (!stopped) begin
      check("transfers_in_frame", idx, NPIX);
      if (rand_cycles == 0) check("cycles_first_valid_to_last", cyc, NPIX);
      @(negedge clk);
      #1;
      check("scan_busy_after_frame", scan_busy, 0);
      check("valid_after_frame", pix_valid, 0);
      check("state_idle_after_frame", dbg_state, IDLE);
    end
  endtask

  initial begin
    int n;
    int bad;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; plot = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0;
    clear_req = 1'b0; scan_start = 1'b0; pix_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_plot_busy", plot_busy, 1);
    check("rst_plot_drop", plot_drop, 0);
    check("rst_scan_busy", scan_busy, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_fields", {pix_x, pix_y, pix_colour}, 0);
    check("rst_state", dbg_state, CLEAR);

    // Automatic clear lasts exactly one write per pixel
    rst_n = 1'b1;
    count_busy(n);
    check("auto_clear_cycles", n, NPIX);
    check("idle_after_clear", dbg_state, IDLE);

    // Two good plots, then two out-of-range ones
    do_plot(8'd3, 7'd2, 3'b100);
    do_plot(8'd159, 7'd119, 3'b010);
    #1;
    check("drop_after_good_plots", plot_drop, 0);
    do_plot(8'd160, 7'd5, 3'b111);
    do_plot(8'd10, 7'd120, 3'b111);
    #1;
    check("drop_after_bad_plots", plot_drop, 1);

    // Backpressured scan of the plotted frame
    run_scan(-1, 3000, 1'b1);

    // Scan again and reset while pixel 500 is presented
    run_scan(500, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midscan_rst_valid", pix_valid, 0);
    check("midscan_rst_state", dbg_state, CLEAR);
    check("midscan_rst_scan_busy", scan_busy, 0);
    check("midscan_rst_drop", plot_drop, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("post_rst_clear_cycles", n, NPIX);

    // Full-rate scan: frame must be blank, no bubbles
    run_scan(-1, 0, 1'b0);

    // clear_req wins over a simultaneous scan_start and clears the drop flag
    do_plot(8'd200, 7'd0, 3'b001);
    #1;
    check("drop_before_clear_req", plot_drop, 1);
    @(negedge clk);
    clear_req = 1'b1;
    scan_start = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    scan_start = 1'b0;
    #1;
    check("collide_state", dbg_state, CLEAR);
    check("collide_plot_busy", plot_busy, 1);
    check("collide_drop_cleared", plot_drop, 0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (scan_busy || pix_valid) bad++;
    end
    check("collide_no_scan", bad, 0);
    check("collide_still_clearing", plot_busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
